// File: rtl/forward_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Register width, the zero register and the stall counter helper live here.
package forward_scoreboard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam int FWD_NONE = 0;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// Priority match of one register query against all in-flight entries.
// The lowest-index (youngest) matching entry wins.
module fwd_match
    import forward_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int LAT_W = 2,
    parameter int IDX_W = 2
) (
    input  logic                        query_valid,
    input  logic [REG_W-1:0]            query_reg,
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH-1:0][REG_W-1:0] ent_wreg,
    input  logic [DEPTH-1:0][LAT_W-1:0] ent_cnt,
    output logic                        hit,
    output logic [IDX_W-1:0]            idx,
    output logic                        ready
);

    logic live;

    assign live = query_valid && (query_reg != REG_ZERO);

    // Walk oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (live && ent_valid[i] && (ent_wreg[i] == query_reg)) begin
                hit   = 1'b1;
                idx   = IDX_W'(i);
                ready = (ent_cnt[i] == '0);
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding/interlock scoreboard: shift register of in-flight writes,
// per-port forward selection, load-use stall and a saturating stall counter.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int NUM_READ = 3,
    parameter int DEPTH = 3,
    parameter int LAT_W = 2,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      issue_valid,
    input  logic [4:0]                issue_wreg,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      ext_stall,
    input  logic                      flush,
    input  logic [NUM_READ-1:0]       rd_valid,
    input  logic [NUM_READ*5-1:0]     rd_reg,
    output logic [NUM_READ*SEL_W-1:0] fwd_sel,
    output logic                      hazard_stall,
    output logic [15:0]               stall_count
);

    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][REG_W-1:0] ent_wreg;
    logic [DEPTH-1:0][LAT_W-1:0] ent_cnt;
    logic [NUM_READ-1:0]         port_stall;
    logic                        issue_ok;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        logic             hit;
        logic             ready;
        logic [SEL_W-1:0] idx;

        fwd_match #(
            .DEPTH (DEPTH),
            .LAT_W (LAT_W),
            .IDX_W (SEL_W)
        ) u_match (
            .query_valid (rd_valid[p]),
            .query_reg   (rd_reg[p*5 +: 5]),
            .ent_valid   (ent_valid),
            .ent_wreg    (ent_wreg),
            .ent_cnt     (ent_cnt),
            .hit         (hit),
            .idx         (idx),
            .ready       (ready)
        );

        assign fwd_sel[p*SEL_W +: SEL_W] =
            (hit && ready) ? idx + SEL_W'(1) : SEL_W'(FWD_NONE);
        assign port_stall[p] = hit && !ready;
    end

    assign hazard_stall = |port_stall;

    assign issue_ok = issue_valid && (issue_wreg != REG_ZERO) &&
                      !hazard_stall && !ext_stall && !flush;

    // Back stages always advance; only entry 0 is gated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid   <= '0;
            ent_wreg    <= '0;
            ent_cnt     <= '0;
            stall_count <= '0;
        end else begin
            ent_valid[0] <= issue_ok;
            ent_wreg[0]  <= issue_wreg;
            ent_cnt[0]   <= issue_lat;
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_wreg[i]  <= ent_wreg[i-1];
                ent_cnt[i]   <= (ent_cnt[i-1] == '0) ? '0
                                : ent_cnt[i-1] - LAT_W'(1);
            end
            if (hazard_stall)
                stall_count <= sat_inc(stall_count);
        end
    end

    a_retire_ready: assert property (
        @(posedge clk) disable iff (!reset_n)
        ent_valid[DEPTH-1] |-> (ent_cnt[DEPTH-1] == '0)
    );

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed testbench for forward_scoreboard (DEPTH=3, NUM_READ=3).
// Each task drives one scenario and compares against hand-computed values.
module tb_forward_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_wreg;
    logic [1:0]  issue_lat;
    logic        ext_stall;
    logic        flush;
    logic [2:0]  rd_valid;
    logic [14:0] rd_reg;
    logic [5:0]  fwd_sel;
    logic        hazard_stall;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    forward_scoreboard #(
        .NUM_READ (3),
        .DEPTH    (3),
        .LAT_W    (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_wreg   (issue_wreg),
        .issue_lat    (issue_lat),
        .ext_stall    (ext_stall),
        .flush        (flush),
        .rd_valid     (rd_valid),
        .rd_reg       (rd_reg),
        .fwd_sel      (fwd_sel),
        .hazard_stall (hazard_stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_wreg  = 5'd0;
        issue_lat   = 2'd0;
        ext_stall   = 1'b0;
        flush       = 1'b0;
        rd_valid    = 3'b000;
        rd_reg      = 15'd0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [1:0] lat);
        issue_valid = 1'b1;
        issue_wreg  = r;
        issue_lat   = lat;
    endtask

    task automatic query(input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [2:0] v);
        rd_reg   = {r2, r1, r0};
        rd_valid = v;
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #2;
        query(5'd5, 5'd5, 5'd5, 3'b111);
        checks++;
        if (fwd_sel !== 6'b000000) begin
            errors++;
            $display("FAIL reset_sel got=%b exp=%b", fwd_sel, 6'b000000);
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall got=%b exp=0", hazard_stall);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count got=%0d exp=0", stall_count);
        end
        tick();
        reset_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_alu_forward();
        logic [5:0] exp_sel [4];
        exp_sel[0] = 6'b010101;
        exp_sel[1] = 6'b101010;
        exp_sel[2] = 6'b111111;
        exp_sel[3] = 6'b000000;
        issue(5'd8, 2'd0);
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_issue_stall got=%b exp=0", hazard_stall);
        end
        tick();
        idle();
        query(5'd8, 5'd8, 5'd8, 3'b111);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (fwd_sel !== exp_sel[k]) begin
                errors++;
                $display("FAIL alu_sel%0d got=%b exp=%b", k, fwd_sel, exp_sel[k]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_load_use();
        issue(5'd9, 2'd1);
        tick();
        issue(5'd10, 2'd0);
        query(5'd9, 5'd0, 5'd0, 3'b000);
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_dead_query got=%b exp=0", hazard_stall);
        end
        query(5'd9, 5'd10, 5'd0, 3'b011);
        checks++;
        if (hazard_stall !== 1'b1 || fwd_sel !== 6'b000000) begin
            errors++;
            $display("FAIL load_stall got=%b/%b exp=1/000000", hazard_stall, fwd_sel);
        end
        tick();
        issue_valid = 1'b0;
        #1;
        checks++;
        if (stall_count !== 16'd1) begin
            errors++;
            $display("FAIL load_count got=%0d exp=1", stall_count);
        end
        checks++;
        if (hazard_stall !== 1'b0 || fwd_sel !== 6'b000010) begin
            errors++;
            $display("FAIL load_fwd got=%b/%b exp=0/000010", hazard_stall, fwd_sel);
        end
        drain();
    endtask

    task automatic test_priority();
        issue(5'd4, 2'd0);
        tick();
        issue(5'd4, 2'd0);
        tick();
        idle();
        query(5'd0, 5'd4, 5'd0, 3'b010);
        checks++;
        if (fwd_sel !== 6'b000100) begin
            errors++;
            $display("FAIL prio_young got=%b exp=000100", fwd_sel);
        end
        drain();
        issue(5'd6, 2'd0);
        tick();
        issue(5'd6, 2'd2);
        tick();
        idle();
        query(5'd6, 5'd0, 5'd0, 3'b001);
        checks++;
        if (hazard_stall !== 1'b1 || fwd_sel !== 6'b000000) begin
            errors++;
            $display("FAIL prio_unready0 got=%b/%b exp=1/000000", hazard_stall, fwd_sel);
        end
        tick();
        checks++;
        if (hazard_stall !== 1'b1 || fwd_sel !== 6'b000000) begin
            errors++;
            $display("FAIL prio_unready1 got=%b/%b exp=1/000000", hazard_stall, fwd_sel);
        end
        tick();
        checks++;
        if (hazard_stall !== 1'b0 || fwd_sel !== 6'b000011) begin
            errors++;
            $display("FAIL prio_ready got=%b/%b exp=0/000011", hazard_stall, fwd_sel);
        end
        checks++;
        if (stall_count !== 16'd3) begin
            errors++;
            $display("FAIL prio_count got=%0d exp=3", stall_count);
        end
        drain();
    endtask

    task automatic test_ext_stall();
        issue(5'd11, 2'd0);
        ext_stall = 1'b1;
        tick();
        idle();
        query(5'd11, 5'd11, 5'd0, 3'b011);
        checks++;
        if (fwd_sel !== 6'b000000) begin
            errors++;
            $display("FAIL ext_stall_sel got=%b exp=000000", fwd_sel);
        end
        drain();
    endtask

    task automatic test_zero_flush();
        issue(5'd0, 2'd0);
        tick();
        idle();
        query(5'd0, 5'd0, 5'd0, 3'b111);
        checks++;
        if (fwd_sel !== 6'b000000 || hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg got=%b/%b exp=000000/0", fwd_sel, hazard_stall);
        end
        drain();
        issue(5'd12, 2'd0);
        tick();
        issue(5'd7, 2'd0);
        flush = 1'b1;
        tick();
        idle();
        query(5'd12, 5'd7, 5'd0, 3'b011);
        checks++;
        if (fwd_sel !== 6'b000010) begin
            errors++;
            $display("FAIL flush_sel0 got=%b exp=000010", fwd_sel);
        end
        tick();
        checks++;
        if (fwd_sel !== 6'b000011) begin
            errors++;
            $display("FAIL flush_sel1 got=%b exp=000011", fwd_sel);
        end
        drain();
    endtask

    task automatic test_async_reset();
        issue(5'd1, 2'd0);
        tick();
        issue(5'd2, 2'd0);
        tick();
        issue(5'd3, 2'd0);
        tick();
        idle();
        query(5'd1, 5'd2, 5'd3, 3'b111);
        checks++;
        if (fwd_sel !== 6'b011011) begin
            errors++;
            $display("FAIL full_sel got=%b exp=011011", fwd_sel);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 6'b000000 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got=%b/%0d exp=000000/0", fwd_sel, stall_count);
        end
        #2;
        reset_n = 1'b1;
        tick();
        checks++;
        if (fwd_sel !== 6'b000000 || hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got=%b/%b exp=000000/0", fwd_sel, hazard_stall);
        end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_priority();
        test_ext_stall();
        test_zero_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
